// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one single-port RAM between two
//               bus masters (requester 0 = CPU, requester 1 = loader/DMA).
//               One access is in flight at a time. The winning command is
//               registered onto the RAM port, held valid for one cycle, and
//               for reads the RAM's one-cycle-latency data is returned to the
//               requester that issued it.
//
// Ports       : clk              - single clock, rising edge
//               reset            - asynchronous, active-low
//               mN_req/addr/wdata/we/mask - requester N command (held until
//                                  mN_ready)
//               mN_ready         - command of requester N accepted this cycle
//               mN_rvalid        - rdata carries requester N's read result
//               rdata            - shared read data
//               memAddress, memWriteData, memWrite, byteMask - RAM command
//               memReadData      - RAM read data (one cycle after address)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic              m0_we,
    input  logic [3:0]        m0_mask,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic              m1_we,
    input  logic [3:0]        m1_mask,

    output logic              m0_ready,
    output logic              m1_ready,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [31:0]       rdata,

    output logic [ADDR_W-1:0] memAddress,
    output logic [31:0]       memWriteData,
    output logic              memWrite,
    output logic [3:0]        byteMask,
    input  logic [31:0]       memReadData
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;      // last granted requester
    logic              sel_q, sel_d;        // requester owning the access
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [3:0]        mask_q, mask_d;

    logic              w_grant0;
    logic              w_grant1;

    // ------------------------------------------------------------------------
    // Arbitration. Grants are only possible in IDLE and are also gated by the
    // reset input itself, so no ready can leak out while reset is held even
    // though the state register already reads IDLE.
    // On a tie the requester that was not served last wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if ((state_q == S_IDLE) && reset) begin
            if (m0_req && m1_req) begin
                w_grant0 = last_q;
                w_grant1 = ~last_q;
            end else begin
                w_grant0 = m0_req;
                w_grant1 = m1_req;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and command capture. memWrite/byteMask are computed here so
    // that they come straight from flops and are high only during ACCESS.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = 1'b0;
        mask_d  = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    state_d = S_ACCESS;
                    sel_d   = w_grant1;
                    last_d  = w_grant1;
                    if (w_grant1) begin
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        write_d = m1_we;
                        mask_d  = m1_we ? m1_mask : 4'b0000;
                    end else begin
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                        write_d = m0_we;
                        mask_d  = m0_we ? m0_mask : 4'b0000;
                    end
                end
            end
            // The registered write flag tells a write (done) from a read
            // (one more cycle to return the RAM data).
            S_ACCESS: state_d = write_q ? S_IDLE : S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            mask_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            mask_q  <= mask_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m0_ready     = w_grant0;
    assign m1_ready     = w_grant1;
    assign m0_rvalid    = (state_q == S_RESP) && !sel_q;
    assign m1_rvalid    = (state_q == S_RESP) &&  sel_q;
    assign rdata        = memReadData;

    assign memAddress   = addr_q;
    assign memWriteData = wdata_q;
    assign memWrite     = write_q;
    assign byteMask     = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a behavioural RAM
//               and a cycle-time reference model for randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_mask, m1_mask;
    logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
    logic [31:0] rdata;
    logic [31:0] memAddress, memWriteData, memReadData;
    logic        memWrite;
    logic [3:0]  byteMask;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] ram [0:255];

    // observations from the access task
    int          obs_rdy, obs_rv, obs_nwr, obs_wcyc, obs_other_rv;
    logic [31:0] obs_rd, obs_wa, obs_wd;
    logic [3:0]  obs_wm;

    logic [31:0] cont_v0, cont_v1;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_req       (m0_req),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_we        (m0_we),
        .m0_mask      (m0_mask),
        .m1_req       (m1_req),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_we        (m1_we),
        .m1_mask      (m1_mask),
        .m0_ready     (m0_ready),
        .m1_ready     (m1_ready),
        .m0_rvalid    (m0_rvalid),
        .m1_rvalid    (m1_rvalid),
        .rdata        (rdata),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .byteMask     (byteMask),
        .memReadData  (memReadData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM, one cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (memWrite) begin
            for (int b = 0; b < 4; b++)
                if (byteMask[b]) ram[memAddress[9:2]][8*b +: 8] <= memWriteData[8*b +: 8];
        end
        memReadData <= ram[memAddress[9:2]];
    end

    task automatic set_cmd(input int m, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mk);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_mask = mk;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_mask = mk;
        end
    endtask

    // Called and returns just after a rising edge.
    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // One complete access by a single requester; records what was observed.
    task automatic access(input int m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] mk);
        obs_rdy = -1; obs_rv = -1; obs_nwr = 0; obs_wcyc = -1; obs_other_rv = 0;
        obs_rd = '0; obs_wa = '0; obs_wd = '0; obs_wm = '0;
        set_cmd(m, 1'b1, we, addr, wd, mk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ready : m1_ready) obs_rdy = cyc;
            @(posedge clk); #1;
            if (obs_rdy >= 0) break;
        end
        set_cmd(m, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (memWrite) begin
                obs_nwr++; obs_wcyc = cyc; obs_wa = memAddress; obs_wd = memWriteData; obs_wm = byteMask;
            end
            if (((m == 0) ? m0_rvalid : m1_rvalid) && obs_rv < 0) begin
                obs_rv = cyc; obs_rd = rdata;
            end
            if ((m == 0) ? m1_rvalid : m0_rvalid) obs_other_rv++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        set_cmd(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_cmd(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (m0_ready !== 1'b0) $display("FAIL rst_m0_ready: got %b want 0", m0_ready); else n_pass++;
            n_checks++; if (m1_ready !== 1'b0) $display("FAIL rst_m1_ready: got %b want 0", m1_ready); else n_pass++;
            n_checks++; if (memWrite !== 1'b0) $display("FAIL rst_memWrite: got %b want 0", memWrite); else n_pass++;
            n_checks++; if (byteMask !== 4'h0) $display("FAIL rst_byteMask: got %h want 0", byteMask); else n_pass++;
            n_checks++; if (memAddress !== 32'h0) $display("FAIL rst_memAddress: got %h want 0", memAddress); else n_pass++;
            n_checks++; if (memWriteData !== 32'h0) $display("FAIL rst_memWriteData: got %h want 0", memWriteData); else n_pass++;
            n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); else n_pass++;
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (m0_ready !== 1'b1) $display("FAIL rst_release_m0_ready: got %b want 1", m0_ready); else n_pass++;
        n_checks++; if (m1_ready !== 1'b0) $display("FAIL rst_release_m1_ready: got %b want 0", m1_ready); else n_pass++;
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (5) begin @(posedge clk); #1; end
    endtask

    task automatic test_write_read_m0();
        access(0, 1'b1, 32'h78, 32'hDEADBEEF, 4'hF);
        n_checks++; if (obs_rdy < 0) $display("FAIL wr0_ready: got timeout want ready"); else n_pass++;
        n_checks++; if (obs_nwr !== 1) $display("FAIL wr0_memWrite_cycles: got %0d want 1", obs_nwr); else n_pass++;
        n_checks++; if (obs_wcyc !== obs_rdy + 1) $display("FAIL wr0_write_cycle: got %0d want %0d", obs_wcyc, obs_rdy + 1); else n_pass++;
        n_checks++; if (obs_wa !== 32'h78) $display("FAIL wr0_addr: got %h want 78", obs_wa); else n_pass++;
        n_checks++; if (obs_wd !== 32'hDEADBEEF) $display("FAIL wr0_data: got %h want deadbeef", obs_wd); else n_pass++;
        n_checks++; if (obs_wm !== 4'hF) $display("FAIL wr0_mask: got %h want f", obs_wm); else n_pass++;
        access(0, 1'b0, 32'h78, 32'h0, 4'h0);
        n_checks++; if (obs_rv - obs_rdy !== 2) $display("FAIL rd0_latency: got %0d want 2", obs_rv - obs_rdy); else n_pass++;
        n_checks++; if (obs_rd !== 32'hDEADBEEF) $display("FAIL rd0_data: got %h want deadbeef", obs_rd); else n_pass++;
        n_checks++; if (obs_other_rv !== 0) $display("FAIL rd0_m1_rvalid: got %0d pulses want 0", obs_other_rv); else n_pass++;
        n_checks++; if (obs_nwr !== 0) $display("FAIL rd0_memWrite: got %0d want 0", obs_nwr); else n_pass++;
    endtask

    task automatic test_mask_m1();
        access(1, 1'b1, 32'h78, 32'hFFFFFFFF, 4'hF);
        access(1, 1'b1, 32'h78, 32'h00000012, 4'b0001);
        n_checks++; if (obs_wm !== 4'b0001) $display("FAIL mask1_byteMask: got %b want 0001", obs_wm); else n_pass++;
        access(1, 1'b0, 32'h78, 32'h0, 4'h0);
        n_checks++; if (obs_rv - obs_rdy !== 2) $display("FAIL mask1_latency: got %0d want 2", obs_rv - obs_rdy); else n_pass++;
        n_checks++; if (obs_rd !== 32'hFFFFFF12) $display("FAIL mask1_data: got %h want ffffff12", obs_rd); else n_pass++;
        n_checks++; if (obs_other_rv !== 0) $display("FAIL mask1_m0_rvalid: got %0d want 0", obs_other_rv); else n_pass++;
    endtask

    task automatic test_contention();
        int g_who[$], g_cyc[$], v_who[$], v_cyc[$];
        logic [31:0] v_dat[$];
        cont_v0 = $urandom;
        cont_v1 = $urandom;
        // preloads through requester 1 leave it as last winner, so 0 wins first
        access(1, 1'b1, 32'h0, cont_v0, 4'hF);
        access(1, 1'b1, 32'h4, cont_v1, 4'hF);
        set_cmd(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_cmd(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (m0_ready) begin g_who.push_back(0); g_cyc.push_back(cyc); end
            if (m1_ready) begin g_who.push_back(1); g_cyc.push_back(cyc); end
            if (m0_rvalid) begin v_who.push_back(0); v_cyc.push_back(cyc); v_dat.push_back(rdata); end
            if (m1_rvalid) begin v_who.push_back(1); v_cyc.push_back(cyc); v_dat.push_back(rdata); end
            @(posedge clk); #1;
            if (i == 13) begin
                set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
                set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        n_checks++; if (g_who.size() !== 5) $display("FAIL cont_grants: got %0d want 5", g_who.size()); else n_pass++;
        n_checks++; if (v_who.size() !== g_who.size()) $display("FAIL cont_rvalids: got %0d want %0d", v_who.size(), g_who.size()); else n_pass++;
        for (int i = 0; i < 4 && i < g_who.size() && i < v_who.size(); i++) begin
            n_checks++; if (g_who[i] !== (i % 2)) $display("FAIL cont_order[%0d]: got %0d want %0d", i, g_who[i], i % 2); else n_pass++;
            if (i > 0) begin
                n_checks++; if (g_cyc[i] - g_cyc[i-1] !== 3) $display("FAIL cont_spacing[%0d]: got %0d want 3", i, g_cyc[i] - g_cyc[i-1]); else n_pass++;
            end
            n_checks++; if (v_who[i] !== (i % 2)) $display("FAIL cont_rv_who[%0d]: got %0d want %0d", i, v_who[i], i % 2); else n_pass++;
            n_checks++; if (v_cyc[i] - g_cyc[i] !== 2) $display("FAIL cont_rv_lat[%0d]: got %0d want 2", i, v_cyc[i] - g_cyc[i]); else n_pass++;
            n_checks++; if (v_dat[i] !== ((i % 2) ? cont_v1 : cont_v0))
                $display("FAIL cont_rdata[%0d]: got %h want %h", i, v_dat[i], (i % 2) ? cont_v1 : cont_v0); else n_pass++;
        end
    endtask

    task automatic test_mixed();
        int t0, t1, rv1, rv0n, start;
        logic [31:0] rd1;
        logic [31:0] wv;
        wv = $urandom;
        t0 = -1; t1 = -1; rv1 = -1; rv0n = 0; rd1 = '0;
        apply_reset();
        start = cyc;
        set_cmd(0, 1'b1, 1'b1, 32'h8, wv, 4'hF);
        set_cmd(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m0_ready && t0 < 0) t0 = cyc;
            if (m1_ready && t1 < 0) t1 = cyc;
            if (m1_rvalid && rv1 < 0) begin rv1 = cyc; rd1 = rdata; end
            if (m0_rvalid) rv0n++;
            @(posedge clk); #1;
            if (t0 >= 0) set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
            if (t1 >= 0) set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        end
        n_checks++; if (t0 !== start) $display("FAIL mixed_m0_first: got cycle %0d want %0d", t0, start); else n_pass++;
        n_checks++; if (t1 - t0 !== 2) $display("FAIL mixed_m1_ready_gap: got %0d want 2", t1 - t0); else n_pass++;
        n_checks++; if (rv1 - t1 !== 2) $display("FAIL mixed_m1_rv_lat: got %0d want 2", rv1 - t1); else n_pass++;
        n_checks++; if (rd1 !== cont_v1) $display("FAIL mixed_m1_rdata: got %h want %h", rd1, cont_v1); else n_pass++;
        n_checks++; if (rv0n !== 0) $display("FAIL mixed_m0_rvalid: got %0d want 0", rv0n); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int seen, n_stale;
        seen = 0;
        set_cmd(0, 1'b1, 1'b0, 32'h78, 32'h0, 4'h0);
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (m0_ready) seen = 1;
            @(posedge clk); #1;
        end
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        n_checks++; if (seen !== 1) $display("FAIL midrst_ready: got timeout want ready"); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (m0_rvalid !== 1'b1) $display("FAIL midrst_rvalid_before: got %b want 1", m0_rvalid); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (m0_rvalid !== 1'b0) $display("FAIL midrst_rvalid_drop: got %b want 0", m0_rvalid); else n_pass++;
        n_checks++; if (memAddress !== 32'h0) $display("FAIL midrst_memAddress: got %h want 0", memAddress); else n_pass++;
        n_checks++; if (memWrite !== 1'b0) $display("FAIL midrst_memWrite: got %b want 0", memWrite); else n_pass++;
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        n_stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid) n_stale++;
            @(posedge clk); #1;
        end
        n_checks++; if (n_stale !== 0) $display("FAIL midrst_stale_rvalid: got %0d want 0", n_stale); else n_pass++;
        access(1, 1'b0, 32'h78, 32'h0, 4'h0);
        n_checks++; if (obs_rv - obs_rdy !== 2) $display("FAIL midrst_m1_latency: got %0d want 2", obs_rv - obs_rdy); else n_pass++;
        n_checks++; if (obs_rd !== 32'hFFFFFF12) $display("FAIL midrst_m1_data: got %h want ffffff12", obs_rd); else n_pass++;
    endtask

    // Randomized traffic from both requesters against a timing model:
    // an accepted write occupies the port until c+2, a read until c+3 with
    // its data due at c+2; ties go to the requester not served last.
    task automatic test_random();
        logic [31:0] ref_mem [0:15];
        logic        act [2];
        logic        we_a [2];
        logic [31:0] ad_a [2], wd_a [2];
        logic [3:0]  mk_a [2];
        int          next_free, last_m, rv_cyc, rv_who, wr_cyc, acc_cyc, c, w, idx;
        logic [31:0] rv_data, wr_data, acc_addr;
        logic [3:0]  wr_mask;
        logic        e_r0, e_r1, e_v0, e_v1, e_wr;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            access(0, 1'b1, 32'h100 + 32'(4 * i), ref_mem[i], 4'hF);
        end
        apply_reset();
        next_free = 0; last_m = 1; rv_cyc = -1; rv_who = 0; wr_cyc = -1; acc_cyc = -1;
        rv_data = '0; wr_data = '0; wr_mask = '0; acc_addr = '0;
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0; we_a[m] = 1'b0; ad_a[m] = '0; wd_a[m] = '0; mk_a[m] = '0;
        end

        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            c = cyc;
            e_r0 = 1'b0; e_r1 = 1'b0;
            if (c >= next_free) begin
                if (act[0] && act[1]) begin
                    e_r0 = (last_m == 1); e_r1 = (last_m == 0);
                end else begin
                    e_r0 = act[0]; e_r1 = act[1];
                end
            end
            e_v0 = (c == rv_cyc) && (rv_who == 0);
            e_v1 = (c == rv_cyc) && (rv_who == 1);
            e_wr = (c == wr_cyc);

            n_checks++; if (m0_ready !== e_r0) $display("FAIL rnd_m0_ready @%0d: got %b want %b", c, m0_ready, e_r0); else n_pass++;
            n_checks++; if (m1_ready !== e_r1) $display("FAIL rnd_m1_ready @%0d: got %b want %b", c, m1_ready, e_r1); else n_pass++;
            n_checks++; if (m0_rvalid !== e_v0) $display("FAIL rnd_m0_rvalid @%0d: got %b want %b", c, m0_rvalid, e_v0); else n_pass++;
            n_checks++; if (m1_rvalid !== e_v1) $display("FAIL rnd_m1_rvalid @%0d: got %b want %b", c, m1_rvalid, e_v1); else n_pass++;
            n_checks++; if (memWrite !== e_wr) $display("FAIL rnd_memWrite @%0d: got %b want %b", c, memWrite, e_wr); else n_pass++;
            n_checks++; if (byteMask !== (e_wr ? wr_mask : 4'h0))
                $display("FAIL rnd_byteMask @%0d: got %h want %h", c, byteMask, e_wr ? wr_mask : 4'h0); else n_pass++;
            if (c == acc_cyc) begin
                n_checks++; if (memAddress !== acc_addr) $display("FAIL rnd_memAddress @%0d: got %h want %h", c, memAddress, acc_addr); else n_pass++;
            end
            if (e_wr) begin
                n_checks++; if (memWriteData !== wr_data) $display("FAIL rnd_memWriteData @%0d: got %h want %h", c, memWriteData, wr_data); else n_pass++;
            end
            if (e_v0 || e_v1) begin
                n_checks++; if (rdata !== rv_data) $display("FAIL rnd_rdata @%0d: got %h want %h", c, rdata, rv_data); else n_pass++;
            end

            if (e_r0 || e_r1) begin
                w = e_r1 ? 1 : 0;
                last_m = w;
                idx = int'((ad_a[w] - 32'h100) >> 2);
                acc_cyc = c + 1;
                acc_addr = ad_a[w];
                if (we_a[w]) begin
                    wr_cyc = c + 1; wr_data = wd_a[w]; wr_mask = mk_a[w];
                    for (int b = 0; b < 4; b++)
                        if (mk_a[w][b]) ref_mem[idx][8*b +: 8] = wd_a[w][8*b +: 8];
                    next_free = c + 2;
                end else begin
                    rv_cyc = c + 2; rv_who = w; rv_data = ref_mem[idx];
                    next_free = c + 3;
                end
                act[w] = 1'b0;
            end

            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (!act[m]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        act[m]  = 1'b1;
                        we_a[m] = $urandom_range(0, 1) == 1;
                        ad_a[m] = 32'h100 + 32'(4 * $urandom_range(0, 15));
                        wd_a[m] = $urandom;
                        mk_a[m] = 4'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    act[m] = 1'b0;   // forfeit before being accepted
                end
                set_cmd(m, act[m], we_a[m], act[m] ? ad_a[m] : 32'h0,
                        act[m] ? wd_a[m] : 32'h0, act[m] ? mk_a[m] : 4'h0);
            end
        end
        set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (5) begin @(posedge clk); #1; end
    endtask

    initial begin
        test_reset();
        test_write_read_m0();
        test_mask_m1();
        test_contention();
        test_mixed();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single RAM port (SPRAM-backed `RAM`) between the `CPU` (requester 0) and a second bus master such as a program loader or DMA engine (requester 1). It sits between the masters and `RAM`. It accepts one access at a time under round-robin priority, drives registered `memAddress`/`memWriteData`/`memWrite`/`byteMask` to the RAM, and returns the RAM's one-cycle-latency read data to the requester that issued the read.

## Interface
Parameters:
- `ADDR_W`, 32: address width of requesters and RAM port.

Ports:
- `clk`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-low (0 = reset).
- `m0_req`, `m1_req`  in  1: access request; held high with stable command until `mN_ready`.
- `m0_addr`, `m1_addr`  in  ADDR_W: byte address.
- `m0_wdata`, `m1_wdata`  in  32: write data.
- `m0_we`, `m1_we`  in  1: 1 = write, 0 = read.
- `m0_mask`, `m1_mask`  in  4: byte enables for writes.
- `m0_ready`, `m1_ready`  out  1: one-cycle pulse, command accepted this cycle.
- `m0_rvalid`, `m1_rvalid`  out  1: one-cycle pulse, `rdata` holds read result.
- `rdata`  out  32: read data, shared by both requesters.
- `memAddress`  out  ADDR_W, `memWriteData` out 32, `memWrite` out 1, `byteMask` out 4: RAM command, all registered.
- `memReadData`  in  32: RAM read data, valid one cycle after the RAM samples the address.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `mN_req` is high, select a winner, pulse `mN_ready` (combinational from state and req), and register its command into the mem outputs. Next state is ACCESS. Also record `sel` (the winner) and `last` (last granted requester).
- Arbitration: one request wins outright. When both request, the winner is the requester ≠ `last`. `last` resets to 1, so requester 0 wins the first tie.
- ACCESS: the mem command is valid for exactly this cycle, and the RAM samples at its closing edge. For a write, `memWrite=1` and `byteMask=mN_mask`, and the next state is IDLE. For a read, `memWrite=0` and `byteMask=4'b0000`, and the next state is RESP.
- RESP: `rdata=memReadData` (passed through combinationally), `m{sel}_rvalid=1`, and the next state is IDLE. No new request is accepted in RESP.
- Outside ACCESS, `memWrite=0` and `byteMask=0`. `memAddress` and `memWriteData` hold their last values.
- `rdata` is unspecified when no `rvalid` is high; the bench must not check it then.
- Addresses and masks pass through unchanged, with no alignment checking.

## Timing
- Reset values: state=IDLE, `last`=1, `memAddress`=0, `memWriteData`=0, `memWrite`=0, `byteMask`=0. All `mN_ready` and `mN_rvalid` are 0.
- Write: `ready` in cycle T, write on the RAM in T+1, next accept possible at T+2. Throughput is one write per 2 cycles.
- Read: `ready` in T, address on the RAM in T+1, `rvalid` and `rdata` in T+2, next accept possible at T+3. Latency from `ready` to `rvalid` is 2 cycles.
- `ready` and `rvalid` are never asserted to both requesters in the same cycle. `rvalid` never coincides with `ready`.
- A requester that drops `req` before `ready` forfeits its request; no partial access is performed.
- A request that arrives in ACCESS or RESP waits until IDLE.
- Reset asserted mid-operation (ACCESS or RESP) forces all outputs to their reset values immediately. An in-flight write may be truncated. An in-flight read is discarded, and no `rvalid` follows.
- With continuous requests from both sides, grants strictly alternate 0,1,0,1…

## Test plan
- Reset: hold `reset=0` with both reqs high → no `ready`, `memWrite=0`, `byteMask=0`, `memAddress=0`. Release reset → `m0_ready` in the first IDLE cycle.
- Single write then read by m0: write addr 0x78, data 0xDEADBEEF, mask 4'b1111 → `memWrite=1` for exactly one cycle. A following read of 0x78 → `m0_rvalid` 2 cycles after `m0_ready`, with `rdata=0xDEADBEEF` and `m1_rvalid=0`.
- Byte-mask write by m1: 0xFFFFFFFF preloaded at 0x78, write 0x00000012 with mask 4'b0001, then read → `rdata=0xFFFFFF12` on `m1_rvalid`.
- Contention: both requesters issue reads continuously (m0 to 0x0, m1 to 0x4) → grant order 0,1,0,1. Each `rvalid` goes to the matching requester, with `rdata` = contents of its own address. Accepts are 3 cycles apart.
- Mixed contention: m0 writes while m1 reads at the same time after reset → m0 is granted first. m1 gets `ready` 2 cycles later, and `m1_rvalid` arrives 2 cycles after that.
- Reset mid-read: assert `reset=0` during RESP → `rvalid` drops at once, and after release no stale `rvalid` appears. A new m1 read then completes normally.
